// File: rtl/io_pkg.sv
// Shared types and address-decode helpers for the CPU-side I/O channel controller.
package io_pkg;

  localparam int DISK_LOC_W = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OUT_WAIT,
    S_OUT_DONE,
    S_IN_WAIT,
    S_IN_DONE,
    S_ACK,
    S_ERR
  } io_state_e;

  function automatic int disk_idx(input int num_dev);
    return num_dev;
  endfunction

  // A request targets a channel only when the bit offset lands on a word boundary.
  function automatic logic addr_valid(input int adr, input int data_w, input int num_dev);
    return ((adr % data_w) == 0) && ((adr / data_w) <= num_dev);
  endfunction

endpackage

// File: rtl/io_timeout_counter.sv
// Per-phase handshake watchdog: counts while enabled, restarts on clr, flags when the budget is used up.
module io_timeout_counter #(
  parameter int TO_W    = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && !expired)
      cnt <= cnt + 1'b1;
  end

  generate
    if (TIMEOUT == 0) begin : g_no_timeout
      assign expired = 1'b0;
    end else begin : g_timeout
      // cnt holds the number of cycles already spent, so the last allowed cycle is TIMEOUT-1.
      assign expired = en && (cnt >= TO_W'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/io_channel_ctrl.sv
// Serialises CPU input/output requests onto NUM_DEV handshaked peripherals plus one disk channel,
// with per-phase timeout, error reporting and a latched disk location.
module io_channel_ctrl
  import io_pkg::*;
#(
  parameter int NUM_DEV = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10,
  parameter int TO_W    = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_W-1:0]         adress,
  input  logic [DATA_W-1:0]         p_data,
  input  logic [31:0]               drs,
  input  logic                      new_out,
  input  logic                      in_req,
  output logic                      out_ready,
  output logic                      in_ready,
  output logic                      io_error,
  output logic [DATA_W-1:0]         e_data,
  input  logic [NUM_DEV*DATA_W-1:0] dev_in,
  output logic [NUM_DEV*DATA_W-1:0] dev_out,
  input  logic [NUM_DEV-1:0]        enter_in,
  output logic [NUM_DEV-1:0]        enter_out,
  input  logic [NUM_DEV-1:0]        done_out,
  output logic                      disk_read,
  output logic                      disk_write,
  input  logic [DATA_W-1:0]         disk_rdata,
  input  logic                      disk_read_done,
  input  logic                      disk_write_done,
  output logic [2:0]                track,
  output logic [4:0]                sector,
  output logic [6:0]                address_in_sector
);

  localparam int IDX_W = $clog2(NUM_DEV + 1);
  localparam int DISK  = disk_idx(NUM_DEV);

  io_state_e          state, next;
  logic [IDX_W-1:0]   idx_q, idx_d, req_idx;
  logic               out_dir_q, dir_d, err_q, err_d, disk_d;
  logic               req_ok, done_sel, in_sel, expired, busy;
  logic [DATA_W-1:0]  in_word;
  logic [NUM_DEV-1:0] enter_out_d;
  logic               disk_write_d, disk_read_d, out_ready_d, in_ready_d, io_error_d;
  logic               unused_drs;

  assign unused_drs = ^drs[31:DISK_LOC_W];
  assign req_ok     = addr_valid(int'(adress), DATA_W, NUM_DEV);
  assign req_idx    = IDX_W'(int'(adress) / DATA_W);

  // Channel and direction are frozen when the request is accepted; later address changes are ignored.
  assign idx_d  = (state == S_IDLE) ? req_idx : idx_q;
  assign dir_d  = (state == S_IDLE) ? new_out : out_dir_q;
  assign disk_d = (idx_d == IDX_W'(DISK));
  assign err_d  = (next == S_ERR) ? 1'b1 : ((state == S_IDLE) ? 1'b0 : err_q);
  assign busy   = (state == S_OUT_WAIT) || (state == S_OUT_DONE) ||
                  (state == S_IN_WAIT)  || (state == S_IN_DONE);

  always_comb begin
    done_sel = 1'b0;
    in_sel   = 1'b0;
    in_word  = disk_rdata;
    if (idx_q == IDX_W'(DISK)) begin
      done_sel = disk_write_done;
      in_sel   = disk_read_done;
    end else begin
      for (int i = 0; i < NUM_DEV; i++) begin
        if (idx_q == IDX_W'(i)) begin
          done_sel = done_out[i];
          in_sel   = enter_in[i];
          in_word  = dev_in[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  io_timeout_counter #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (next != state),
    .en      (busy),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      S_IDLE: begin
        if (new_out || in_req) begin
          if (!req_ok)      next = S_ERR;
          else if (new_out) next = S_OUT_WAIT;
          else              next = S_IN_WAIT;
        end
      end
      S_OUT_WAIT: if (expired) next = S_ERR; else if (done_sel)  next = S_OUT_DONE;
      S_OUT_DONE: if (expired) next = S_ERR; else if (!done_sel) next = S_ACK;
      S_IN_WAIT:  if (expired) next = S_ERR; else if (in_sel)    next = S_IN_DONE;
      S_IN_DONE:  if (expired) next = S_ERR; else if (!in_sel)   next = S_ACK;
      S_ERR:      next = S_ACK;
      S_ACK:      next = S_IDLE;
      default:    next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state and registered, so strobes never glitch.
  always_comb begin
    enter_out_d  = '0;
    disk_write_d = 1'b0;
    disk_read_d  = 1'b0;
    out_ready_d  = 1'b0;
    in_ready_d   = 1'b0;
    io_error_d   = 1'b0;
    case (next)
      S_OUT_WAIT: begin
        if (disk_d)
          disk_write_d = 1'b1;
        else
          for (int i = 0; i < NUM_DEV; i++) enter_out_d[i] = (idx_d == IDX_W'(i));
      end
      S_IN_WAIT: disk_read_d = disk_d;
      S_ACK: begin
        out_ready_d = dir_d && !err_d;
        in_ready_d  = !dir_d && !err_d;
      end
      S_ERR: begin
        io_error_d  = 1'b1;
        out_ready_d = dir_d;
        in_ready_d  = !dir_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enter_out  <= '0;
      disk_write <= 1'b0;
      disk_read  <= 1'b0;
      out_ready  <= 1'b0;
      in_ready   <= 1'b0;
      io_error   <= 1'b0;
      idx_q      <= '0;
      out_dir_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      enter_out  <= enter_out_d;
      disk_write <= disk_write_d;
      disk_read  <= disk_read_d;
      out_ready  <= out_ready_d;
      in_ready   <= in_ready_d;
      io_error   <= io_error_d;
      idx_q      <= idx_d;
      out_dir_q  <= dir_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dev_out                             <= '0;
      e_data                              <= '0;
      {track, sector, address_in_sector}  <= '0;
    end else begin
      if ((state == S_IDLE) && (new_out || in_req) && req_ok)
        {track, sector, address_in_sector} <= drs[DISK_LOC_W-1:0];
      if ((state == S_IDLE) && (next == S_OUT_WAIT) && !disk_d)
        for (int i = 0; i < NUM_DEV; i++)
          if (idx_d == IDX_W'(i)) dev_out[i*DATA_W +: DATA_W] <= p_data;
      if ((state == S_IN_WAIT) && (next == S_IN_DONE))
        e_data <= in_word;
      // A failed input never leaves stale data visible to the CPU.
      if ((next == S_ERR) && !dir_d)
        e_data <= '0;
    end
  end

endmodule

// File: tb/tb_io_channel_ctrl.sv
// Transaction-level randomized bench for io_channel_ctrl with a handshake-timing reference model.
module tb_io_channel_ctrl;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [AW-1:0]   adress;
  logic [DW-1:0]   p_data;
  logic [31:0]     drs;
  logic            new_out, in_req;
  logic            out_ready, in_ready, io_error;
  logic [DW-1:0]   e_data;
  logic [N*DW-1:0] dev_in, dev_out;
  logic [N-1:0]    enter_in, enter_out, done_out;
  logic            disk_read, disk_write;
  logic [DW-1:0]   disk_rdata;
  logic            disk_read_done, disk_write_done;
  logic [2:0]      track;
  logic [4:0]      sector;
  logic [6:0]      address_in_sector;

  always #5 clk = ~clk;

  io_channel_ctrl #(
    .NUM_DEV (N), .DATA_W (DW), .ADDR_W (AW), .TO_W (16), .TIMEOUT (TO)
  ) dut (
    .clk (clk), .rst_n (rst_n), .adress (adress), .p_data (p_data), .drs (drs),
    .new_out (new_out), .in_req (in_req), .out_ready (out_ready), .in_ready (in_ready),
    .io_error (io_error), .e_data (e_data), .dev_in (dev_in), .dev_out (dev_out),
    .enter_in (enter_in), .enter_out (enter_out), .done_out (done_out),
    .disk_read (disk_read), .disk_write (disk_write), .disk_rdata (disk_rdata),
    .disk_read_done (disk_read_done), .disk_write_done (disk_write_done),
    .track (track), .sector (sector), .address_in_sector (address_in_sector)
  );

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] mem [N];
  logic [DW-1:0] edata_m;
  logic [14:0]   loc_m;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state();
    for (int i = 0; i < N; i++) check("dev_out", 64'(dev_out[i*DW +: DW]), 64'(mem[i]));
    check("e_data", 64'(e_data), 64'(edata_m));
    check("track", 64'(track), 64'(loc_m[14:12]));
    check("sector", 64'(sector), 64'(loc_m[11:7]));
    check("addr_in_sector", 64'(address_in_sector), 64'(loc_m[6:0]));
  endtask

  task automatic set_resp(input bit out, input int ch, input logic v, input logic [DW-1:0] data);
    if (out) begin
      if (ch == N) disk_write_done = v;
      else         done_out[ch]    = v;
    end else begin
      if (ch == N) begin disk_read_done = v; disk_rdata = data; end
      else begin enter_in[ch] = v; dev_in[ch*DW +: DW] = data; end
    end
  endtask

  // d: cycles after the request is taken before the peripheral responds; h: cycles it holds the response.
  task automatic xfer(input bit out, input int adr, input logic [DW-1:0] data,
                      input int d, input int h, input logic [31:0] drs_v);
    int ch, lat, wend, c;
    bit valid, err, seen, in_win;
    ch    = adr / DW;
    valid = ((adr % DW) == 0) && (ch <= N);
    if (!valid)            begin err = 1; lat = 1;          wend = 0;     end
    else if (d + 1 >= TO)  begin err = 1; lat = TO + 1;     wend = TO;    end
    else if (h >= TO)      begin err = 1; lat = 2 + d + TO; wend = 1 + d; end
    else                   begin err = 0; lat = 2 + d + h;  wend = 1 + d; end
    @(negedge clk);
    adress = AW'(adr);
    p_data = data;
    drs    = drs_v;
    if (out) new_out = 1'b1; else in_req = 1'b1;
    c = 0;
    seen = 0;
    while (!seen && c < 60) begin
      @(posedge clk); #1;
      c++;
      if (c == 1) begin adress = AW'($urandom); drs = $urandom; end
      if (valid && c == 1 + d)     set_resp(out, ch, 1'b1, data);
      if (valid && c == 1 + d + h) set_resp(out, ch, 1'b0, data);
      in_win = valid && (c <= wend);
      check("enter_out", 64'(enter_out), 64'((out && in_win && ch < N) ? (1 << ch) : 0));
      check("disk_write", 64'(disk_write), 64'(out && in_win && ch == N));
      check("disk_read", 64'(disk_read), 64'(!out && in_win && ch == N));
      seen = out_ready || in_ready || io_error;
    end
    check("latency", 64'(c), 64'(lat));
    check("out_ready", 64'(out_ready), 64'(out));
    check("in_ready", 64'(in_ready), 64'(!out));
    check("io_error", 64'(io_error), 64'(err));
    new_out = 1'b0;
    in_req  = 1'b0;
    if (valid) begin
      set_resp(out, ch, 1'b0, data);
      loc_m = drs_v[14:0];
      if (out && ch < N) mem[ch] = data;
    end
    if (!out) edata_m = err ? '0 : data;
    @(posedge clk); #1;
    check("pulse_width", 64'({out_ready, in_ready, io_error}), 64'(0));
    @(posedge clk); #1;
    check_state();
  endtask

  initial begin
    int out_c, in_c, c, adr, d, h;
    bit both;
    logic [DW-1:0] a_val, b_val;
    rst_n = 1'b0; adress = '0; p_data = '0; drs = '0; new_out = 1'b0; in_req = 1'b0;
    dev_in = '0; enter_in = '0; done_out = '0; disk_rdata = '0;
    disk_read_done = 1'b0; disk_write_done = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = '0;
    edata_m = '0;
    loc_m   = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_strobes", 64'({enter_out, disk_read, disk_write}), 64'(0));
    check("reset_pulses", 64'({out_ready, in_ready, io_error}), 64'(0));
    check_state();
    @(negedge clk) rst_n = 1'b1;

    xfer(1, 64, 32'hDEADBEEF, 3, 2, $urandom);
    xfer(0, 32, 32'h12345678, 2, 3, $urandom);
    xfer(0, 128, $urandom, 2, 1, 32'h1A5F);
    xfer(1, 128, $urandom, 1, 2, $urandom);
    xfer(1, 0, $urandom, 0, 1, $urandom);
    xfer(1, 96, $urandom, 100, 1, $urandom);
    xfer(0, 0, $urandom, 100, 1, $urandom);
    xfer(0, 64, $urandom, 1, 12, $urandom);
    xfer(1, 40, $urandom, 0, 1, $urandom);
    xfer(0, 160, $urandom, 0, 1, $urandom);

    // Output and input requested together on channel 0.
    a_val = $urandom;
    b_val = $urandom;
    @(negedge clk);
    adress = '0; p_data = a_val; drs = $urandom; new_out = 1'b1; in_req = 1'b1;
    loc_m = drs[14:0];
    out_c = 0; in_c = 0; c = 0; both = 0;
    while (in_c == 0 && c < 60) begin
      @(posedge clk); #1;
      c++;
      done_out[0] = enter_out[0];
      if (out_ready && in_ready) both = 1;
      if (in_ready) in_c = c;
      if (out_ready && out_c == 0) begin out_c = c; new_out = 1'b0; end
      if (out_c > 0 && c == out_c + 4) begin enter_in[0] = 1'b1; dev_in[DW-1:0] = b_val; end
      if (out_c > 0 && c == out_c + 5) enter_in[0] = 1'b0;
    end
    in_req = 1'b0;
    check("both_ready", 64'(both), 64'(0));
    check("out_first_latency", 64'(out_c), 64'(3));
    check("in_after_out", 64'(in_c), 64'(out_c + 6));
    mem[0]  = a_val;
    edata_m = b_val;
    repeat (2) @(posedge clk);
    #1;
    check_state();

    // Reset while the output strobe is active.
    @(negedge clk);
    adress = AW'(64); p_data = $urandom; new_out = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("strobe_before_reset", 64'(enter_out), 64'(4'b0100));
    #2 rst_n = 1'b0;
    #1;
    new_out = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = '0;
    edata_m = '0;
    loc_m   = '0;
    check("reset_mid_strobes", 64'({enter_out, disk_write, disk_read}), 64'(0));
    check("reset_mid_pulses", 64'({out_ready, in_ready, io_error}), 64'(0));
    check_state();
    @(negedge clk) rst_n = 1'b1;
    xfer(1, 32, $urandom, 0, 1, $urandom);

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 9))
        8:       adr = $urandom_range(0, N) * DW + $urandom_range(1, DW - 1);
        9:       adr = $urandom_range(N + 1, 31) * DW;
        default: adr = $urandom_range(0, N) * DW;
      endcase
      d = ($urandom_range(0, 9) == 0) ? $urandom_range(7, 12) : $urandom_range(0, 5);
      h = ($urandom_range(0, 9) == 0) ? $urandom_range(8, 10) : $urandom_range(1, 5);
      xfer(1'($urandom_range(0, 1)), adr, $urandom, d, h, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
